// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew based stall and forward controller for the
// pipelined MIPS core. A small shadow pipeline records the destination and
// remaining Tnew of each instruction past D. The D-stage sources are matched
// against it to decide whether to stall and where to forward from. A
// down-counter tracks how long the HI/LO multiply/divide unit stays busy.
module hazard_scoreboard #(
    parameter int REG_W    = 5,
    parameter int STAGES   = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [TW-1:0]    d_tuse_rs,
    input  logic [TW-1:0]    d_tuse_rt,
    input  logic [REG_W-1:0] d_wr_addr,
    input  logic [TW-1:0]    d_tnew,
    input  logic             d_md_start,
    input  logic             d_md_div,
    input  logic             d_md_use,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic             md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    // Shadow pipeline: index 1 is E, STAGES is the oldest tracked stage.
    logic [STAGES:1] valid_q, valid_d;
    logic [REG_W-1:0] addr_q [1:STAGES];
    logic [REG_W-1:0] addr_d [1:STAGES];
    logic [TW-1:0]    tnew_q [1:STAGES];
    logic [TW-1:0]    tnew_d [1:STAGES];

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic             rs_hit, rt_hit;
    logic [TW-1:0]    rs_tnew, rt_tnew;
    logic [SEL_W-1:0] rs_stage, rt_stage;
    logic             stall_rs, stall_rt, stall_md, hz_stall, accept;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    // Find the youngest matching entry per source; scanning from the oldest
    // stage down lets the youngest match overwrite any older one.
    always_comb begin
        rs_hit   = 1'b0;
        rt_hit   = 1'b0;
        rs_tnew  = '0;
        rt_tnew  = '0;
        rs_stage = '0;
        rt_stage = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (valid_q[k] && (addr_q[k] == d_rs) && (d_rs != '0) &&
                (d_tuse_rs != TUSE_NONE)) begin
                rs_hit   = 1'b1;
                rs_tnew  = tnew_q[k];
                rs_stage = SEL_W'(k);
            end
            if (valid_q[k] && (addr_q[k] == d_rt) && (d_rt != '0) &&
                (d_tuse_rt != TUSE_NONE)) begin
                rt_hit   = 1'b1;
                rt_tnew  = tnew_q[k];
                rt_stage = SEL_W'(k);
            end
        end
    end

    // Turn the matches into stall causes and forward selects.
    always_comb begin
        stall_rs = rs_hit && (rs_tnew > d_tuse_rs);
        stall_rt = rt_hit && (rt_tnew > d_tuse_rt);
        stall_md = d_valid && (d_md_start || d_md_use) && (md_cnt_q != '0);
        hz_stall = d_valid && (stall_rs || stall_rt || stall_md);
        accept   = d_valid && !hz_stall;
        rs_sel   = (rs_hit && (rs_tnew == '0)) ? rs_stage : '0;
        rt_sel   = (rt_hit && (rt_tnew == '0)) ? rt_stage : '0;
    end

    // Outputs are forced quiet while reset is held, whatever the inputs.
    always_comb begin
        stall      = !reset && hz_stall;
        fwd_rs_sel = reset ? '0 : rs_sel;
        fwd_rt_sel = reset ? '0 : rt_sel;
        md_busy    = !reset && (md_cnt_q != '0);
    end

    // Next state: shift the shadow pipeline, age Tnew, load or bubble E,
    // apply flush, and run the HI/LO busy counter (flush leaves it alone).
    always_comb begin
        valid_d[1] = accept;
        addr_d[1]  = d_wr_addr;
        tnew_d[1]  = d_tnew;
        for (int k = 2; k <= STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            addr_d[k]  = addr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
        end
        if (flush) begin
            valid_d = '0;
        end

        md_cnt_d = md_cnt_q;
        if (accept && d_md_start) begin
            md_cnt_d = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset discarding all in-flight state.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            md_cnt_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                addr_q[k] <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            md_cnt_q <= md_cnt_d;
            for (int k = 1; k <= STAGES; k++) begin
                addr_q[k] <= addr_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios for the hazard scoreboard with
// hand-computed stall / forward / busy expectations checked by assertions.
module tb_hazard_scoreboard;

    localparam int REG_W = 5;
    localparam int TW    = 2;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             d_valid = 1'b0;
    logic [REG_W-1:0] d_rs = '0;
    logic [REG_W-1:0] d_rt = '0;
    logic [TW-1:0]    d_tuse_rs = '1;
    logic [TW-1:0]    d_tuse_rt = '1;
    logic [REG_W-1:0] d_wr_addr = '0;
    logic [TW-1:0]    d_tnew = '0;
    logic             d_md_start = 1'b0;
    logic             d_md_div = 1'b0;
    logic             d_md_use = 1'b0;
    logic             flush = 1'b0;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic             md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(
        .REG_W(REG_W), .STAGES(3), .TW(TW),
        .MULT_LAT(5), .DIV_LAT(10), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .flush(flush), .stall(stall),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Drive one D-stage cycle on the falling edge, then settle for the check.
    task automatic applyStimulus(input int valid, input int rs, input int rt,
                                 input int tuse_rs, input int tuse_rt,
                                 input int wr, input int tnew,
                                 input int md_start, input int md_div,
                                 input int md_use, input int fl);
        @(negedge clk);
        d_valid    = (valid != 0);
        d_rs       = REG_W'(rs);
        d_rt       = REG_W'(rt);
        d_tuse_rs  = TW'(tuse_rs);
        d_tuse_rt  = TW'(tuse_rt);
        d_wr_addr  = REG_W'(wr);
        d_tnew     = TW'(tnew);
        d_md_start = (md_start != 0);
        d_md_div   = (md_div != 0);
        d_md_use   = (md_use != 0);
        flush      = (fl != 0);
        #1;
    endtask

    // One assertion per comparison; failures are counted and reported.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Directed scenario sequence; each applyStimulus call is one cycle.
    initial begin
        // Held in reset, with an md_use instruction presented.
        applyStimulus(1, 8, 8, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 8, 8, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("reset_stall", int'(stall), 0);
        checkOutput("reset_fwd_rs", int'(fwd_rs_sel), 0);
        checkOutput("reset_busy", int'(md_busy), 0);
        reset = 1'b0;

        // lw $8 (tnew 2) then addu $9,$8,$1 (tuse 1).
        applyStimulus(1, 29, 0, 1, 3, 8, 2, 0, 0, 0, 0);
        checkOutput("lw_issue_stall", int'(stall), 0);
        applyStimulus(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
        checkOutput("lw_use_stall", int'(stall), 1);
        checkOutput("lw_use_fwd_stalled", int'(fwd_rs_sel), 0);
        applyStimulus(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
        checkOutput("lw_use_release", int'(stall), 0);
        checkOutput("lw_use_fwd_m_not_ready", int'(fwd_rs_sel), 0);

        // addu $3 (tnew 1) then beq $3,$0 (tuse 0).
        applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("beq_stall", int'(stall), 1);
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("beq_release", int'(stall), 0);
        checkOutput("beq_fwd_m", int'(fwd_rs_sel), 2);
        checkOutput("beq_fwd_rt_zero", int'(fwd_rt_sel), 0);

        // Two writers of $5 back to back; the youngest (E) wins.
        applyStimulus(1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
        checkOutput("dup_stall", int'(stall), 0);
        checkOutput("dup_fwd_rs_e", int'(fwd_rs_sel), 1);
        checkOutput("dup_fwd_rt_e", int'(fwd_rt_sel), 1);

        // Youngest $5 still pending hides an older ready copy.
        applyStimulus(1, 1, 2, 1, 1, 5, 2, 0, 0, 0, 0);
        applyStimulus(1, 5, 5, 2, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("young_pending_stall", int'(stall), 1);
        checkOutput("young_pending_fwd_rs", int'(fwd_rs_sel), 0);
        applyStimulus(1, 5, 5, 2, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("young_pending_release", int'(stall), 0);
        checkOutput("young_pending_fwd_rt", int'(fwd_rt_sel), 0);

        // Write to $0 then read $0: never a hazard.
        applyStimulus(1, 1, 2, 3, 3, 0, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_stall", int'(stall), 0);
        checkOutput("r0_fwd", int'(fwd_rs_sel), 0);

        // Unused sources (tuse all-ones) and a self-referencing destination.
        applyStimulus(1, 1, 2, 1, 1, 7, 2, 0, 0, 0, 0);
        applyStimulus(1, 7, 7, 3, 3, 7, 0, 0, 0, 0, 0);
        checkOutput("unused_src_stall", int'(stall), 0);
        checkOutput("unused_src_fwd", int'(fwd_rs_sel), 0);

        // lw $8 reaches E, gets flushed; dependent read sees nothing.
        applyStimulus(1, 1, 2, 1, 1, 8, 2, 0, 0, 0, 0);
        applyStimulus(0, 8, 8, 1, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("invalid_d_no_stall", int'(stall), 0);
        applyStimulus(1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_stall", int'(stall), 0);
        checkOutput("flush_fwd", int'(fwd_rs_sel), 0);

        // div then mflo: stalled for exactly 10 cycles.
        applyStimulus(1, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0);
        checkOutput("div_issue_busy", int'(md_busy), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 3, 3, 2, 1, 0, 0, 1, 0);
            checkOutput($sformatf("div_mflo_stall_%0d", i), int'(stall), 1);
            checkOutput($sformatf("div_busy_%0d", i), int'(md_busy), 1);
        end
        applyStimulus(1, 0, 0, 3, 3, 2, 1, 0, 0, 1, 0);
        checkOutput("div_mflo_release", int'(stall), 0);
        checkOutput("div_idle", int'(md_busy), 0);

        // mult then mflo: stalled for exactly 5 cycles.
        applyStimulus(1, 3, 4, 1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 3, 3, 2, 1, 0, 0, 1, 0);
            checkOutput($sformatf("mult_mflo_stall_%0d", i), int'(stall), 1);
        end
        applyStimulus(1, 0, 0, 3, 3, 2, 1, 0, 0, 1, 0);
        checkOutput("mult_mflo_release", int'(stall), 0);

        // mult writing $9 accepted in a flush cycle: counter loads, entry dies.
        applyStimulus(1, 3, 4, 1, 1, 9, 2, 1, 0, 0, 1);
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_md_busy", int'(md_busy), 1);
        checkOutput("flush_md_entry_killed", int'(stall), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("flush_md_still_busy", int'(md_busy), 1);
        applyStimulus(1, 1, 2, 1, 1, 10, 2, 1, 1, 0, 0);
        checkOutput("div2_issue_busy", int'(md_busy), 0);
        checkOutput("div2_issue_stall", int'(stall), 0);

        // Reset in the middle of the divide.
        reset = 1'b1;
        applyStimulus(1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("midreset_stall", int'(stall), 0);
        checkOutput("midreset_busy", int'(md_busy), 0);
        checkOutput("midreset_fwd", int'(fwd_rs_sel), 0);
        reset = 1'b0;
        applyStimulus(1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("post_reset_busy", int'(md_busy), 0);
        checkOutput("post_reset_stall", int'(stall), 0);

        // Forwarding from E, then from the oldest stage (W).
        applyStimulus(1, 1, 2, 1, 1, 11, 0, 0, 0, 0, 0);
        applyStimulus(1, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fwd_e_rs", int'(fwd_rs_sel), 1);
        checkOutput("fwd_e_rt", int'(fwd_rt_sel), 1);
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fwd_w_rs", int'(fwd_rs_sel), 3);
        checkOutput("fwd_w_stall", int'(stall), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
